// File: rtl/chaos_dac_pkg.sv
// Shared types, constants and pair-select helper for the chaos DAC frame scheduler.
package chaos_dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ITERATE,
    CAPTURE,
    CONVERT,
    PUBLISH
  } state_t;

  localparam int unsigned F32_BIAS  = 127;
  localparam int unsigned FRAC_BITS = 10;
  localparam int unsigned MANT_W    = 23;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SAMPLE_W  = 14;
  localparam int unsigned MAG_W     = 13;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_IDX_W  = 2;
  localparam int unsigned CNT_W     = 16;

  // Exponent window where the magnitude is neither zero nor saturated.
  localparam int unsigned EXP_MIN    = F32_BIAS - FRAC_BITS;          // 117
  localparam int unsigned EXP_SAT    = F32_BIAS + MAG_W - FRAC_BITS;  // 130
  localparam int unsigned SHIFT_BASE = F32_BIAS + MANT_W - FRAC_BITS; // 140

  localparam logic [SAMPLE_W-1:0] MIDSCALE = 14'h2000;
  localparam logic [MAG_W-1:0]    MAG_MAX  = 13'h1FFF;

  localparam logic [CH_IDX_W-1:0] CH_X = 2'd0;
  localparam logic [CH_IDX_W-1:0] CH_Y = 2'd1;
  localparam logic [CH_IDX_W-1:0] CH_Z = 2'd2;
  localparam logic [CH_IDX_W-1:0] CH_W = 2'd3;

  typedef struct packed {
    logic                hit;
    logic [CH_IDX_W-1:0] a;
    logic [CH_IDX_W-1:0] b;
  } pair_sel_t;

  // First matching pair wins; no match leaves hit low so outputs hold.
  function automatic pair_sel_t pick_pair(input logic [NUM_CH-1:0] sel);
    pair_sel_t p;
    p = '{hit: 1'b0, a: CH_X, b: CH_Y};
    if (sel[0] && sel[1])      p = '{hit: 1'b1, a: CH_X, b: CH_Y};
    else if (sel[0] && sel[2]) p = '{hit: 1'b1, a: CH_X, b: CH_Z};
    else if (sel[0] && sel[3]) p = '{hit: 1'b1, a: CH_X, b: CH_W};
    else if (sel[1] && sel[2]) p = '{hit: 1'b1, a: CH_Y, b: CH_Z};
    else if (sel[1] && sel[3]) p = '{hit: 1'b1, a: CH_Y, b: CH_W};
    else if (sel[2] && sel[3]) p = '{hit: 1'b1, a: CH_Z, b: CH_W};
    return p;
  endfunction

endpackage

// File: rtl/chaos_dac_scheduler_f32_to_i14.sv
// Combinational IEEE-754 single to 14-bit offset-binary converter (Q3.10, saturating).
module f32_to_i14
  import chaos_dac_pkg::*;
(
  input  logic [WORD_W-1:0]   value,
  output logic [SAMPLE_W-1:0] sample_c
);

  logic              sign;
  logic [EXP_W-1:0]  expo;
  logic [MANT_W:0]   mant;
  logic [EXP_W-1:0]  shift;
  logic [MANT_W:0]   scaled;
  logic [MAG_W-1:0]  mag;

  always_comb begin
    sign   = value[WORD_W-1];
    expo   = value[WORD_W-2:MANT_W];
    mant   = {1'b1, value[MANT_W-1:0]};
    shift  = EXP_W'(SHIFT_BASE) - expo;
    scaled = mant >> shift;
    mag    = '0;
    // Inf/NaN land in the saturating branch because their exponent is all ones.
    if (expo >= EXP_W'(EXP_SAT)) begin
      mag = MAG_MAX;
    end else if (expo >= EXP_W'(EXP_MIN)) begin
      mag = scaled[MAG_W-1:0];
    end
    sample_c = sign ? {1'b0, ~mag} : {1'b1, mag};
  end

endmodule

// File: rtl/chaos_dac_scheduler.sv
// Frame sequencer: gates the chaos generator, snapshots its states, converts them
// through one shared converter and publishes the selected channel pair to the DACs.
module chaos_dac_scheduler
  import chaos_dac_pkg::*;
#(
  parameter int unsigned ITER_CYCLES = 39
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                RUN,
  input  logic [NUM_CH-1:0]   SEL,
  input  logic [WORD_W-1:0]   CHAOS_X,
  input  logic [WORD_W-1:0]   CHAOS_Y,
  input  logic [WORD_W-1:0]   CHAOS_Z,
  input  logic [WORD_W-1:0]   CHAOS_W,
  output logic                CHAOS_EN,
  output logic [SAMPLE_W-1:0] OUT_DA,
  output logic [SAMPLE_W-1:0] OUT_DB,
  output logic                OUT_VALID,
  output logic                BUSY
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_CYCLES - 1);

  state_t state, state_next;

  logic [CNT_W-1:0]                 iter_cnt;
  logic [CH_IDX_W-1:0]              conv_idx;
  logic [NUM_CH-1:0][WORD_W-1:0]    snap;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  chan;
  logic [SAMPLE_W-1:0]              conv_sample_c;
  pair_sel_t                        pair_c;

  logic en_next;
  logic busy_next;
  logic valid_next;

  assign pair_c = pick_pair(SEL);

  f32_to_i14 u_conv (
    .value    (snap[conv_idx]),
    .sample_c (conv_sample_c)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and next values of the registered strobes.
  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    busy_next  = 1'b0;
    valid_next = 1'b0;
    case (state)
      IDLE:    if (RUN) state_next = ITERATE;
      ITERATE: if (iter_cnt == ITER_LAST) state_next = CAPTURE;
      CAPTURE: state_next = CONVERT;
      CONVERT: if (conv_idx == CH_W) state_next = PUBLISH;
      PUBLISH: begin
        state_next = RUN ? ITERATE : IDLE;
        valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    en_next   = (state_next == ITERATE);
    busy_next = (state_next != IDLE);
  end

  // Datapath: iteration counter, snapshot, conversion slots and DAC outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CHAOS_EN  <= 1'b0;
      BUSY      <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DA    <= MIDSCALE;
      OUT_DB    <= MIDSCALE;
      iter_cnt  <= '0;
      conv_idx  <= '0;
      snap      <= '0;
      chan      <= {NUM_CH{MIDSCALE}};
    end else begin
      CHAOS_EN  <= en_next;
      BUSY      <= busy_next;
      OUT_VALID <= valid_next;
      iter_cnt  <= (state == ITERATE) ? iter_cnt + CNT_W'(1) : '0;
      case (state)
        CAPTURE: begin
          snap     <= {CHAOS_W, CHAOS_Z, CHAOS_Y, CHAOS_X};
          conv_idx <= '0;
        end
        CONVERT: begin
          chan[conv_idx] <= conv_sample_c;
          conv_idx       <= conv_idx + CH_IDX_W'(1);
        end
        PUBLISH: begin
          if (pair_c.hit) begin
            OUT_DA <= chan[pair_c.a];
            OUT_DB <= chan[pair_c.b];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_dac_scheduler.sv
// Self-checking bench for chaos_dac_scheduler: vector table through a scoreboard
// queue, plus idle, stop-after-frame and mid-frame reset sequences.
module tb_chaos_dac_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RUN;
  logic [3:0]  SEL;
  logic [31:0] CHAOS_X, CHAOS_Y, CHAOS_Z, CHAOS_W;
  logic        CHAOS_EN;
  logic [13:0] OUT_DA, OUT_DB;
  logic        OUT_VALID;
  logic        BUSY;

  chaos_dac_scheduler #(.ITER_CYCLES(39)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RUN       (RUN),
    .SEL       (SEL),
    .CHAOS_X   (CHAOS_X),
    .CHAOS_Y   (CHAOS_Y),
    .CHAOS_Z   (CHAOS_Z),
    .CHAOS_W   (CHAOS_W),
    .CHAOS_EN  (CHAOS_EN),
    .OUT_DA    (OUT_DA),
    .OUT_DB    (OUT_DB),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] x, y, z, w;
    logic [13:0] da, db;
    bit          scramble;
  } vec_t;

  typedef struct {
    logic [13:0] da, db;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  exp_t exp_q [$];

  int checks = 0;
  int failures = 0;
  int cyc_since = 0;
  int en_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Wait for the next OUT_VALID (bounded), then score frame timing and the published pair.
  task automatic wait_frame(input bit scramble, input bit check_period);
    bit   got = 1'b0;
    bit   en_prev = CHAOS_EN;
    bit   arm = 1'b0;
    bit   done = 1'b0;
    exp_t e;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge CLK);
      cyc_since++;
      if (arm) begin
        CHAOS_X = 32'h41200000;
        arm = 1'b0;
        done = 1'b1;
      end
      if (scramble && !done && en_prev && !CHAOS_EN) arm = 1'b1;
      if (OUT_VALID) got = 1'b1;
      else if (CHAOS_EN) en_cnt++;
      en_prev = CHAOS_EN;
    end
    check("valid_seen", 32'(got), 32'd1);
    if (got) begin
      check("en_cycles", 32'(en_cnt), 32'd39);
      if (check_period) check("valid_period", 32'(cyc_since), 32'd45);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("out_da", 32'(OUT_DA), 32'(e.da));
        check("out_db", 32'(OUT_DB), 32'(e.db));
      end
    end
    cyc_since = 0;
    en_cnt = CHAOS_EN ? 1 : 0;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    SEL = v.sel;
    CHAOS_X = v.x;
    CHAOS_Y = v.y;
    CHAOS_Z = v.z;
    CHAOS_W = v.w;
    e.da = v.da;
    e.db = v.db;
    exp_q.push_back(e);
  endtask

  task automatic watch_idle(input int n, input string name, input logic [13:0] da, input logic [13:0] db);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (OUT_VALID || BUSY || CHAOS_EN || OUT_DA !== da || OUT_DB !== db) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0011, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 14'h2400, 14'h1BFF, 1'b0};
    vecs[1]  = '{4'b0011, 32'h3F000000, 32'h00000000, 32'h0, 32'h0, 14'h2200, 14'h2000, 1'b0};
    vecs[2]  = '{4'b0011, 32'h00000000, 32'h41200000, 32'h0, 32'h0, 14'h2000, 14'h3FFF, 1'b0};
    vecs[3]  = '{4'b0011, 32'h41200000, 32'hC1200000, 32'h0, 32'h0, 14'h3FFF, 14'h0000, 1'b0};
    vecs[4]  = '{4'b1100, 32'h3F800000, 32'h3F800000, 32'h3F000000, 32'hBF800000, 14'h2200, 14'h1BFF, 1'b0};
    vecs[5]  = '{4'b1111, 32'h3F000000, 32'h3F800000, 32'h3F000000, 32'hBF800000, 14'h2200, 14'h2400, 1'b1};
    vecs[6]  = '{4'b0001, 32'h41200000, 32'h0, 32'h0, 32'h0, 14'h2200, 14'h2400, 1'b0};
    vecs[7]  = '{4'b0101, 32'hBF000000, 32'h0, 32'h3A800000, 32'h0, 14'h1DFF, 14'h2001, 1'b0};
    vecs[8]  = '{4'b1010, 32'h0, 32'h3A000000, 32'h0, 32'h7F800000, 14'h2000, 14'h3FFF, 1'b0};
    vecs[9]  = '{4'b0110, 32'h0, 32'h40FFFFFF, 32'hFFC00000, 32'h0, 14'h3FFF, 14'h0000, 1'b0};
    vecs[10] = '{4'b1001, 32'h3FC00000, 32'h0, 32'h0, 32'h41000000, 14'h2600, 14'h3FFF, 1'b0};
    vecs[11] = '{4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 14'h2600, 14'h3FFF, 1'b0};
    vecs[12] = '{4'b0011, 32'h80000000, 32'h3DCCCCCD, 32'h0, 32'h0, 14'h1FFF, 14'h2066, 1'b0};

    RST_N = 1'b0;
    RUN = 1'b0;
    SEL = 4'b0000;
    CHAOS_X = '0;
    CHAOS_Y = '0;
    CHAOS_Z = '0;
    CHAOS_W = '0;

    // Reset state, then quiet idle with RUN low.
    repeat (3) @(negedge CLK);
    check("rst_da", 32'(OUT_DA), 32'h2000);
    check("rst_db", 32'(OUT_DB), 32'h2000);
    check("rst_en", 32'(CHAOS_EN), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    RST_N = 1'b1;
    watch_idle(100, "idle_quiet", 14'h2000, 14'h2000);

    // Back-to-back frames, one table vector per frame.
    cyc_since = 0;
    en_cnt = 0;
    apply(vecs[0]);
    RUN = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      if (i > 0) apply(vecs[i]);
      wait_frame(vecs[i].scramble, i > 0);
      check("busy_running", 32'(BUSY), 32'd1);
    end

    // RUN dropped at ITERATE cycle 10: one more frame, then idle.
    begin
      exp_t e;
      e.da = 14'h1FFF;
      e.db = 14'h2066;
      exp_q.push_back(e);
    end
    repeat (10) @(negedge CLK);
    cyc_since += 10;
    en_cnt += 10;
    RUN = 1'b0;
    wait_frame(1'b0, 1'b1);
    check("stop_busy", 32'(BUSY), 32'd0);
    check("stop_en", 32'(CHAOS_EN), 32'd0);
    watch_idle(100, "stop_idle", 14'h1FFF, 14'h2066);

    // Reset asserted during CONVERT discards the frame immediately.
    SEL = 4'b0011;
    CHAOS_X = 32'h3F800000;
    CHAOS_Y = 32'hBF800000;
    RUN = 1'b1;
    begin
      bit saw_en = 1'b0;
      bit in_cap = 1'b0;
      for (int n = 0; n < 100 && !in_cap; n++) begin
        @(negedge CLK);
        if (CHAOS_EN) saw_en = 1'b1;
        else if (saw_en) in_cap = 1'b1;
      end
      check("capture_seen", 32'(in_cap), 32'd1);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midrst_da", 32'(OUT_DA), 32'h2000);
    check("midrst_db", 32'(OUT_DB), 32'h2000);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_valid", 32'(OUT_VALID), 32'd0);
    RUN = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    watch_idle(60, "midrst_idle", 14'h2000, 14'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chaos_dac_scheduler.md
Name: chaos_dac_scheduler

Overview:
Frame sequencer between the Chaos_Generator and the dual-port DAC data registers. Each frame it:
- gates the generator's ENABLE for a fixed iteration window;
- snapshots the four 32-bit float states (X, Y, Z, W);
- converts them one at a time through a single shared float-to-14-bit converter;
- publishes the switch-selected channel pair to OUT_DA/OUT_DB with a one-cycle valid strobe.

It runs in the CLK_50 domain and feeds the DAC output registers.

Parameters:
ITER_CYCLES, 39, number of cycles CHAOS_EN is held high per frame (legal range 1..65535); frame period = ITER_CYCLES+6 (45 by default).

Ports:
CLK  in  1  system clock (50 MHz)
RST_N  in  1  asynchronous active-low reset
RUN  in  1  level; 1 = free-running frames, 0 = stop after the current frame
SEL  in  4  channel-pair select switches (bit0=X, bit1=Y, bit2=Z, bit3=W)
CHAOS_X, CHAOS_Y, CHAOS_Z, CHAOS_W  in  32 each  IEEE-754 single-precision generator states
CHAOS_EN  out  1  generator enable
OUT_DA  out  14  offset-binary sample for DAC port A
OUT_DB  out  14  offset-binary sample for DAC port B
OUT_VALID  out  1  one-cycle pulse: OUT_DA/OUT_DB just updated
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; CHAOS_EN=0; OUT_VALID=0; BUSY=0; OUT_DA=OUT_DB=14'h2000 (midscale); channel registers=14'h2000; snapshot regs=0; counters=0.
- All outputs are registered.
- IDLE: if RUN=1, go to ITERATE next cycle; counter=0.
- ITERATE: CHAOS_EN=1 for exactly ITER_CYCLES cycles; counter increments. At counter==ITER_CYCLES-1, go to CAPTURE.
- CAPTURE (1 cycle): CHAOS_EN=0; latch CHAOS_X..W into snapshot regs. Generator outputs are stable here because ENABLE is low.
- CONVERT (4 cycles): index 0..3 selects snapshot X,Y,Z,W into the shared converter. The combinational result is written to channel register[index] on the same edge. After index 3, go to PUBLISH.
- PUBLISH (1 cycle): sample SEL and apply pair priority, first match wins:
  - X,Y if SEL[0]&SEL[1]
  - X,Z if SEL[0]&SEL[2]
  - X,W if SEL[0]&SEL[3]
  - Y,Z if SEL[1]&SEL[2]
  - Y,W if SEL[1]&SEL[3]
  - Z,W if SEL[2]&SEL[3]
  - otherwise OUT_DA/OUT_DB hold their previous values.
- PUBLISH update: on the edge leaving PUBLISH, OUT_DA/OUT_DB load the selected pair and OUT_VALID is 1 for the next cycle. OUT_VALID pulses even when no pair matches (values held).
- PUBLISH exit: go to ITERATE if RUN=1 (back-to-back frames, no gap), else IDLE.
- RUN=0 mid-frame: the current frame completes, including publish, then the block goes to IDLE. RUN is only sampled in IDLE and PUBLISH.
- Reset mid-frame: immediate return to reset values. A partially converted frame is discarded.
- Conversion (f32_to_i14), sign s, exponent e, mantissa m:
  - magnitude M = floor(|x|*1024), from {1,m} shifted by (e-127).
  - e<117 (|x|<2^-10, includes zero/denormal): M=0.
  - |x|>=8 (e>=130): saturate M=8191.
  - NaN/Inf: saturate M=8191 with the sign as given.
  - Output = s ? {1'b0, ~M[12:0]} : {1'b1, M[12:0]}.

Decomposition:
- Package chaos_dac_pkg holds:
  - state enum (IDLE, ITERATE, CAPTURE, CONVERT, PUBLISH);
  - localparams F32_BIAS=127, FRAC_BITS=10, MIDSCALE=14'h2000, MAG_MAX=13'h1FFF;
  - channel index constants CH_X=0..CH_W=3.
- One sub-module: f32_to_i14, purely combinational, 32 in / 14 out. Instantiated once and time-shared by the CONVERT state.

Test Plan:
- Reset/idle: RST_N low with RUN=0 -> OUT_DA=OUT_DB=0x2000, CHAOS_EN=0, BUSY=0. After release with RUN=0 for 100 cycles, nothing toggles.
- Frame timing: RUN=1 constant, ITER_CYCLES=39 -> CHAOS_EN high for exactly 39 cycles per frame, OUT_VALID period exactly 45 cycles, CHAOS_EN rises the cycle after OUT_VALID's frame ends.
- Conversion values (SEL=4'b0011, X/Y driven):
  - X=0x3F800000 (+1.0) -> OUT_DA=0x2400; Y=0xBF800000 (-1.0) -> OUT_DB=0x1BFF
  - X=0x3F000000 (+0.5) -> 0x2200; X=0x00000000 -> 0x2000
  - X=0x41200000 (+10) -> 0x3FFF; X=0xC1200000 (-10) -> 0x0000
- Pair priority: Z=+0.5, W=-1.0, SEL=4'b1100 -> OUT_DA=0x2200, OUT_DB=0x1BFF. SEL=4'b1111 -> X,Y pair. SEL=4'b0001 -> outputs hold and OUT_VALID still pulses.
- Snapshot isolation: change CHAOS_X during CONVERT/PUBLISH -> published value equals the one present in the CAPTURE cycle.
- Stop/reset mid-frame: drop RUN at ITERATE cycle 10 -> one more OUT_VALID, then IDLE with BUSY=0. Assert RST_N low during CONVERT -> no OUT_VALID, outputs return to 0x2000 immediately.
